// File: rtl/rom_seq_reader_pkg.sv
// -----------------------------------------------------------------------------
// rom_seq_reader_pkg
// Shared definitions for the ROM address sequencer and the 8x4 ROM beside it.
//   DEF_ADDR_W / DEF_DATA_W : default ROM geometry (8 words of 4 bits)
//   state_t                 : controller state encoding
// -----------------------------------------------------------------------------
package rom_seq_reader_pkg;

    localparam int DEF_ADDR_W = 3;
    localparam int DEF_DATA_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rom_seq_reader.sv
// -----------------------------------------------------------------------------
// rom_seq_reader
// Walks an inclusive (wrapping) ROM address range, one address per cycle,
// forwarding each word with its address tag and keeping a running sum.
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   start                 : scan request, only honoured in IDLE
//   first_addr, last_addr : inclusive scan range, latched on accepted start
//   rom_addr / rom_data   : ROM read port (ROM is combinational)
//   data_out, data_addr   : captured word and the address it came from
//   data_valid            : one strobe per captured word
//   sum                   : running sum of the current scan's words
//   busy                  : high in READ and DONE
//   done                  : pulse coinciding with the final word
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; outputs hold the previous scan result
// READ    | rom_addr presented, word captured every cycle
// DONE    | final word is on data_out; single cycle, then back to IDLE
// -----------------------------------------------------------------------------
module rom_seq_reader
    import rom_seq_reader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int SUM_W  = ADDR_W + DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] data_out,
    output logic [ADDR_W-1:0] data_addr,
    output logic              data_valid,
    output logic [SUM_W-1:0]  sum,
    output logic              busy,
    output logic              done
);

    state_t            state;
    logic [ADDR_W-1:0] last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_q     <= '0;
            rom_addr   <= '0;
            data_out   <= '0;
            data_addr  <= '0;
            data_valid <= 1'b0;
            sum        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            done       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        last_q   <= last_addr;
                        rom_addr <= first_addr;
                        sum      <= '0;
                        busy     <= 1'b1;
                        state    <= ST_READ;
                    end
                end
                ST_READ: begin
                    data_out   <= rom_data;
                    data_addr  <= rom_addr;
                    data_valid <= 1'b1;
                    sum        <= sum + SUM_W'(rom_data);
                    if (rom_addr == last_q) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        // Natural ADDR_W-bit overflow gives the 7 -> 0 wrap.
                        rom_addr <= rom_addr + ADDR_W'(1);
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_seq_reader.sv
module tb_rom_seq_reader;
    import rom_seq_reader_pkg::*;

    localparam int AW = 3;
    localparam int DW = 4;
    localparam int SW = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] first_addr = '0;
    logic [AW-1:0] last_addr = '0;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic [DW-1:0] data_out;
    logic [AW-1:0] data_addr;
    logic          data_valid;
    logic [SW-1:0] sum;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    // ROM model: word[i] = 2*i+1
    assign rom_data = {rom_addr, 1'b1};

    rom_seq_reader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .data_out   (data_out),
        .data_addr  (data_addr),
        .data_valid (data_valid),
        .sum        (sum),
        .busy       (busy),
        .done       (done)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] psum;
        logic          last;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: every strobe must match the oldest expected word.
    always @(negedge clk) begin
        if (data_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected: got addr=%0d data=%0d expected no strobe",
                         data_addr, data_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (data_addr !== e.addr || data_out !== e.data ||
                    sum !== e.psum || done !== e.last) begin
                    errors++;
                    $display("FAIL strobe: got addr=%0d data=%0d sum=%0d done=%0d expected addr=%0d data=%0d sum=%0d done=%0d",
                             data_addr, data_out, sum, done, e.addr, e.data, e.psum, e.last);
                end
            end
        end
    end

    // Hand-computed expectations are passed in; the queue is filled from them.
    task automatic run_scan(input int f, input int l, input int n, input int total,
                            input int inj_k, input int rst_k);
        int   k;
        int   busy_cnt;
        int   done_k;
        int   done_sum;
        int   acc;
        exp_t e;
        acc = 0;
        for (int j = 0; j < n; j++) begin
            e.addr = AW'((f + j) % 8);
            e.data = DW'(2 * ((f + j) % 8) + 1);
            acc    = acc + 2 * ((f + j) % 8) + 1;
            e.psum = SW'(acc);
            e.last = (j == n - 1);
            if (rst_k == 0 || j + 2 <= rst_k) exp_q.push_back(e);
        end
        @(negedge clk);
        first_addr = AW'(f);
        last_addr  = AW'(l);
        start      = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        k = 0; busy_cnt = 0; done_k = 0; done_sum = -1;
        forever begin
            @(negedge clk);
            k++;
            if (busy) busy_cnt++;
            if (done) begin
                done_k   = k;
                done_sum = int'(sum);
            end
            if (rst_k != 0 && k == rst_k) begin
                rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
                @(negedge clk);
                chk("reset_mid_scan_outputs",
                    int'({rom_addr, data_out, data_addr, sum, data_valid, done, busy}), 0);
                break;
            end
            if (inj_k != 0 && k == inj_k) begin
                start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
            if (!busy && k > 1) break;
            if (k > 40) begin
                errors++;
                $display("FAIL scan_timeout: got busy still high after %0d cycles expected completion", k);
                break;
            end
        end
        if (rst_k == 0) begin
            chk("busy_cycles", busy_cnt, n + 1);
            chk("done_latency", done_k, n + 1);
            chk("final_sum", done_sum, total);
        end
        repeat (3) @(negedge clk);
        #1;
        chk("no_restart_busy", int'(busy), 0);
        chk("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs",
            int'({rom_addr, data_out, data_addr, sum, data_valid, done, busy}), 0);

        run_scan(0, 7, 8, 64, 0, 0);   // full scan
        run_scan(2, 4, 3, 21, 0, 0);   // sub-range
        run_scan(6, 1, 4, 32, 0, 0);   // wrap 7 -> 0
        run_scan(3, 3, 1, 7, 0, 0);    // single word
        chk("sum_held_in_idle", int'(sum), 7);
        run_scan(0, 7, 8, 64, 2, 0);   // start ignored while busy
        run_scan(0, 7, 8, 64, 0, 3);   // reset in 3rd READ cycle
        run_scan(0, 1, 2, 4, 0, 0);    // clean scan after reset

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/rom_seq_reader.md
Name: rom_seq_reader

Overview:
- Address-sequencing controller that sits directly upstream of the 8x4 combinational ROM.
- Drives the ROM address port and walks an inclusive address range.
- Captures each returned word and forwards it downstream with a valid strobe and its address tag.
- Accumulates a running sum and signals completion with a start/busy/done handshake.

Parameters:
ADDR_W, 3, ROM address width; the ROM depth is 2**ADDR_W.
DATA_W, 4, ROM data width.
SUM_W, ADDR_W+DATA_W (7), accumulator width; holds the full-ROM worst case of 8*15=120 without overflow.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  one-cycle request to begin a scan; sampled only in IDLE.
first_addr  input  ADDR_W  first address of the scan; latched on an accepted start.
last_addr  input  ADDR_W  last address of the scan (inclusive); latched on an accepted start.
rom_addr  output  ADDR_W  address to the ROM, registered.
rom_data  input  DATA_W  ROM read data; combinational with respect to rom_addr.
data_out  output  DATA_W  captured ROM word, registered.
data_addr  output  ADDR_W  address that data_out was read from.
data_valid  output  1  one-cycle strobe per captured word.
sum  output  SUM_W  running sum of the words captured in the current scan.
busy  output  1  high while in READ or DONE.
done  output  1  one-cycle pulse marking the final word.

Behaviour:
- Reset (rst=1 at a clock edge, in any state, including mid-scan):
  - state to IDLE.
  - rom_addr, data_out, data_addr, sum cleared to 0.
  - data_valid, done, busy cleared to 0.
  - Latched range discarded.
- FSM states: IDLE, READ, DONE.
- IDLE:
  - busy=0.
  - On start=1: latch last_addr, set rom_addr<=first_addr, clear sum, go to READ.
  - sum keeps the previous result until the next accepted start.
- READ (one address per cycle):
  - Each cycle: data_out<=rom_data, data_addr<=rom_addr, data_valid<=1, sum<=sum+zero-extended rom_data.
  - If rom_addr==latched last: go to DONE and set done<=1.
  - Otherwise rom_addr<=rom_addr+1, modulo 2**ADDR_W.
- Wrap-around: if last < first, the scan wraps 7 to 0. The word count is N=((last-first) mod 2**ADDR_W)+1. first==last reads exactly 1 word.
- DONE:
  - Lasts one cycle; the last word's data_valid and done are high together, and sum is final in this cycle.
  - Next state is IDLE; data_valid and done return to 0.
- Latency:
  - start sampled at edge E0 gives the first data_valid in cycle E0+2.
  - done is high in cycle E0+N+1.
  - busy is high for N+1 cycles.
- start while busy (READ or DONE) is ignored; it is not queued.
- A start in the IDLE cycle that immediately follows DONE is accepted normally.
- rom_addr holds its last value in IDLE.
- No overflow is possible at the default widths. Widths are enforced by SUM_W; the adder is SUM_W bits and truncates.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_READ=2'd1, ST_DONE=2'd2.
  - default ADDR_W/DATA_W constants, shared with the ROM.
- No sub-module. The controller is a single FSM plus address counter and accumulator. The ROM is instantiated beside it at the top level, not inside it.

Test Plan:
Bench ROM model for all scenarios: word[i]=2*i+1, i.e. 1,3,5,7,9,11,13,15. ROM is combinational.
1. Full scan: first=0, last=7, start pulse -> 8 data_valid strobes with data_addr 0..7 and data_out 1..15 odd; done coincides with the 8th strobe, when sum=64; busy high for 9 cycles.
2. Sub-range: first=2, last=4 -> data_out 5,7,9; done with sum=21; done 4 cycles after the start edge.
3. Wrap: first=6, last=1 -> data_addr 6,7,0,1 and data_out 13,15,1,3; sum=32.
4. Single word: first=last=3 -> exactly one strobe with data_out=7; done in the same cycle; sum=7; busy for 2 cycles.
5. start pulsed in the 2nd READ cycle of a 0..7 scan -> ignored; the scan completes with sum=64; no second scan starts.
6. rst asserted in the 3rd READ cycle -> next cycle all outputs 0 and state IDLE; a subsequent start with 0..1 yields sum=4.
